// File: rtl/int_writeback_merge_buffer_pkg.sv
// Shared types for the integer writeback merge buffer: lane entry, active-list writeback record,
// execution states and the wrap-aware flush-range test.
package int_writeback_merge_buffer_pkg;

  localparam int DATA_W              = 32;
  localparam int PREG_W              = 7;
  localparam int ALPTR_W             = 6;
  localparam int ADDR_W              = 32;
  localparam int INSN_ADDR_BIT_WIDTH = 2;

  localparam int DEF_LANES    = 4;
  localparam int DEF_WR_PORTS = 2;
  localparam int DEF_DEPTH    = 8;
  localparam int DEPTH_IDX_W  = $clog2(DEF_DEPTH);
  localparam int OCC_W        = DEPTH_IDX_W + 1;

  typedef logic [DEPTH_IDX_W-1:0] depth_idx_t;

  typedef enum logic [2:0] {
    EXEC_STATE_SUCCESS               = 3'd0,
    EXEC_STATE_REFETCH_NEXT          = 3'd1,
    EXEC_STATE_FAULT_INSN_MISALIGNED = 3'd2
  } execution_state_t;

  typedef struct packed {
    logic [ALPTR_W-1:0] al_ptr;
    logic               write_reg;
    logic [PREG_W-1:0]  phy_dst;
    logic [DATA_W-1:0]  data;
    logic               data_valid;
    logic               is_branch;
    logic               br_valid;
    logic               br_miss;
    logic [ADDR_W-1:0]  next_addr;
  } wb_entry_t;

  typedef struct packed {
    logic [ALPTR_W-1:0] ptr;
    execution_state_t   state;
    logic [ADDR_W-1:0]  fault_addr;
  } al_wb_data_t;

  // [head, tail) modulo the pointer space; head == tail is an empty range.
  function automatic logic in_flush_range(input logic [ALPTR_W-1:0] ptr,
                                          input logic [ALPTR_W-1:0] head,
                                          input logic [ALPTR_W-1:0] tail,
                                          input logic en);
    if (!en) return 1'b0;
    if (head <= tail) return (ptr >= head) && (ptr < tail);
    return (ptr >= head) || (ptr < tail);
  endfunction

endpackage

// File: rtl/int_writeback_merge_buffer_compactor.sv
// Prefix-sum compaction: each kept lane gets its offset from the buffer tail, plus the total kept.
module wb_lane_compactor #(
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]            keep,
  output logic [LANES-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = count;
      count     = count + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/int_writeback_merge_buffer.sv
// Merges LANES results into WR_PORTS writeback ports via an age-ordered buffer; 1 cycle accept-to-write.
// in_ready drops when fewer than LANES slots are free; optional INT_WB_PERF_COUNTER_EN adds perf counters.
module int_writeback_merge_buffer
  import int_writeback_merge_buffer_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int WR_PORTS = DEF_WR_PORTS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                stall,
  input  logic                                clear,
  input  logic [LANES-1:0]                    in_valid,
  input  wb_entry_t [LANES-1:0]               in_entry,
  output logic                                in_ready,
  input  logic                                flush_en,
  input  logic [ALPTR_W-1:0]                  flush_head,
  input  logic [ALPTR_W-1:0]                  flush_tail,
  output logic [LANES-1:0]                    replay_valid,
  output logic [LANES-1:0][ALPTR_W-1:0]       replay_al_ptr,
  output logic [WR_PORTS-1:0]                 rf_we,
  output logic [WR_PORTS-1:0][PREG_W-1:0]     rf_num,
  output logic [WR_PORTS-1:0][DATA_W-1:0]     rf_data,
  output logic [WR_PORTS-1:0]                 al_we,
  output al_wb_data_t [WR_PORTS-1:0]          al_data,
  output logic [WR_PORTS-1:0]                 br_valid,
  output logic [WR_PORTS-1:0][ADDR_W-1:0]     br_next_addr,
  output logic [$clog2(DEPTH):0]              occupancy
`ifdef INT_WB_PERF_COUNTER_EN
  ,
  output logic [31:0]                         perf_full_cycles,
  output logic [31:0]                         perf_max_occ
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OC_W  = IDX_W + 1;
  localparam int CNT_W = $clog2(LANES + 1);

  wb_entry_t                          mem [DEPTH];
  logic [DEPTH-1:0]                   slot_vld;
  logic [IDX_W-1:0]                   head, tail;
  logic                               accept, drain;
  logic [LANES-1:0]                   keep;
  logic [LANES-1:0][CNT_W-1:0]        offset;
  logic [CNT_W-1:0]                   push_cnt;
  logic [OC_W-1:0]                    pop_cnt;
  logic [LANES-1:0][IDX_W-1:0]        wr_idx;
  logic [WR_PORTS-1:0][IDX_W-1:0]     rd_idx;
  logic [WR_PORTS-1:0]                live;

  assign in_ready = (OC_W'(DEPTH) - occupancy) >= OC_W'(LANES);
  assign accept   = in_ready && !stall && !clear && !rst;
  assign drain    = !stall && !clear && !rst;

  // Flushed lanes vanish; data-invalid lanes go to replay instead of the buffer.
  always_comb begin
    keep          = '0;
    replay_valid  = '0;
    replay_al_ptr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (accept && in_valid[i] &&
          !in_flush_range(in_entry[i].al_ptr, flush_head, flush_tail, flush_en)) begin
        keep[i]         = in_entry[i].data_valid;
        replay_valid[i] = !in_entry[i].data_valid;
        if (!in_entry[i].data_valid) replay_al_ptr[i] = in_entry[i].al_ptr;
      end
    end
  end

  wb_lane_compactor #(.LANES(LANES), .CNT_W(CNT_W)) u_compactor (
    .keep   (keep),
    .offset (offset),
    .count  (push_cnt)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) wr_idx[i] = tail + IDX_W'(offset[i]);
  end

  always_comb begin
    if (!drain)                               pop_cnt = '0;
    else if (occupancy < OC_W'(WR_PORTS))     pop_cnt = occupancy;
    else                                      pop_cnt = OC_W'(WR_PORTS);
  end

  // Invalidated window slots still pop, they just keep every enable low.
  always_comb begin
    rf_we        = '0;
    rf_num       = '0;
    rf_data      = '0;
    al_we        = '0;
    al_data      = '0;
    br_valid     = '0;
    br_next_addr = '0;
    for (int k = 0; k < WR_PORTS; k++) begin
      rd_idx[k] = head + IDX_W'(k);
      live[k]   = drain && (OC_W'(k) < occupancy) && slot_vld[rd_idx[k]] &&
                  !in_flush_range(mem[rd_idx[k]].al_ptr, flush_head, flush_tail, flush_en);
      if (live[k]) begin
        rf_we[k]          = mem[rd_idx[k]].write_reg;
        rf_num[k]         = mem[rd_idx[k]].phy_dst;
        rf_data[k]        = mem[rd_idx[k]].data;
        al_we[k]          = 1'b1;
        br_valid[k]       = mem[rd_idx[k]].br_valid;
        br_next_addr[k]   = mem[rd_idx[k]].next_addr;
        al_data[k].ptr    = mem[rd_idx[k]].al_ptr;
        al_data[k].state  = mem[rd_idx[k]].br_miss ? EXEC_STATE_REFETCH_NEXT : EXEC_STATE_SUCCESS;
        if (mem[rd_idx[k]].br_valid &&
            mem[rd_idx[k]].next_addr[INSN_ADDR_BIT_WIDTH-1:0] != '0) begin
          al_data[k].state      = EXEC_STATE_FAULT_INSN_MISALIGNED;
          al_data[k].fault_addr = mem[rd_idx[k]].next_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) mem[wr_idx[i]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      slot_vld  <= '0;
    end else if (!stall) begin
      for (int d = 0; d < DEPTH; d++) begin
        if (in_flush_range(mem[d].al_ptr, flush_head, flush_tail, flush_en)) slot_vld[d] <= 1'b0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (keep[i]) slot_vld[wr_idx[i]] <= 1'b1;
      end
      head      <= head + IDX_W'(pop_cnt);
      tail      <= tail + IDX_W'(push_cnt);
      occupancy <= occupancy + OC_W'(push_cnt) - pop_cnt;
    end
  end

`ifdef INT_WB_PERF_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles <= '0;
      perf_max_occ     <= '0;
    end else begin
      if (!in_ready && !stall && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (32'(occupancy) > perf_max_occ) perf_max_occ <= 32'(occupancy);
    end
  end
`endif

endmodule

// File: tb/tb_int_writeback_merge_buffer.sv
// Bench for int_writeback_merge_buffer: queue-based reference model plus directed literal checks.
module tb_int_writeback_merge_buffer;
  import int_writeback_merge_buffer_pkg::*;

  localparam int LANES    = 4;
  localparam int WR_PORTS = 2;
  localparam int DEPTH    = 8;

  logic                            clk = 1'b0;
  logic                            rst, stall, clear, flush_en;
  logic [LANES-1:0]                in_valid;
  wb_entry_t [LANES-1:0]           in_entry;
  logic                            in_ready;
  logic [ALPTR_W-1:0]              flush_head, flush_tail;
  logic [LANES-1:0]                replay_valid;
  logic [LANES-1:0][ALPTR_W-1:0]   replay_al_ptr;
  logic [WR_PORTS-1:0]             rf_we, al_we, br_valid;
  logic [WR_PORTS-1:0][PREG_W-1:0] rf_num;
  logic [WR_PORTS-1:0][DATA_W-1:0] rf_data;
  al_wb_data_t [WR_PORTS-1:0]      al_data;
  logic [WR_PORTS-1:0][ADDR_W-1:0] br_next_addr;
  logic [$clog2(DEPTH):0]          occupancy;
`ifdef INT_WB_PERF_COUNTER_EN
  logic [31:0]                     perf_full_cycles, perf_max_occ;
`endif

  always #5 clk = ~clk;

  int_writeback_merge_buffer #(.LANES(LANES), .WR_PORTS(WR_PORTS), .DEPTH(DEPTH)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_entry      (in_entry),
    .in_ready      (in_ready),
    .flush_en      (flush_en),
    .flush_head    (flush_head),
    .flush_tail    (flush_tail),
    .replay_valid  (replay_valid),
    .replay_al_ptr (replay_al_ptr),
    .rf_we         (rf_we),
    .rf_num        (rf_num),
    .rf_data       (rf_data),
    .al_we         (al_we),
    .al_data       (al_data),
    .br_valid      (br_valid),
    .br_next_addr  (br_next_addr),
    .occupancy     (occupancy)
`ifdef INT_WB_PERF_COUNTER_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_max_occ     (perf_max_occ)
`endif
  );

  typedef struct {
    wb_entry_t e;
    bit        vld;
  } mslot_t;

  mslot_t mq[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pointer is flushed when its distance from head is shorter than the range length.
  function automatic bit m_flushed(input logic [ALPTR_W-1:0] p, input logic [ALPTR_W-1:0] h,
                                   input logic [ALPTR_W-1:0] t, input bit en);
    logic [ALPTR_W-1:0] dp, dt;
    dp = p - h;
    dt = t - h;
    return en && (dp < dt);
  endfunction

  function automatic wb_entry_t mk(input int ptr, input int phy, input bit wr, input bit dv,
                                   input bit brv, input bit brm, input logic [31:0] na,
                                   input logic [31:0] dat);
    wb_entry_t e;
    e            = '0;
    e.al_ptr     = ALPTR_W'(ptr);
    e.phy_dst    = PREG_W'(phy);
    e.write_reg  = wr;
    e.data_valid = dv;
    e.is_branch  = brv;
    e.br_valid   = brv;
    e.br_miss    = brm;
    e.next_addr  = na;
    e.data       = dat;
    return e;
  endfunction

  task automatic idle();
    in_valid   = '0;
    in_entry   = '0;
    stall      = 1'b0;
    clear      = 1'b0;
    flush_en   = 1'b0;
    flush_head = '0;
    flush_tail = '0;
  endtask

  // Settle the current inputs and compare every output against the model.
  task automatic look();
    logic [LANES-1:0]                e_rv;
    logic [LANES-1:0][ALPTR_W-1:0]   e_rp;
    logic [WR_PORTS-1:0]             e_rfwe, e_alwe, e_brv;
    logic [WR_PORTS-1:0][PREG_W-1:0] e_num;
    logic [WR_PORTS-1:0][DATA_W-1:0] e_dat;
    logic [WR_PORTS-1:0][ADDR_W-1:0] e_adr;
    al_wb_data_t [WR_PORTS-1:0]      e_al;
    wb_entry_t                       e;
    bit                              rdy, acc, drn;
    int                              occ;
    #1;
    occ = mq.size();
    rdy = (DEPTH - occ) >= LANES;
    acc = rdy && !stall && !clear && !rst;
    drn = !stall && !clear && !rst;
    e_rv = '0; e_rp = '0; e_rfwe = '0; e_alwe = '0; e_brv = '0;
    e_num = '0; e_dat = '0; e_adr = '0; e_al = '0;
    for (int i = 0; i < LANES; i++) begin
      if (acc && in_valid[i] && !in_entry[i].data_valid &&
          !m_flushed(in_entry[i].al_ptr, flush_head, flush_tail, flush_en)) begin
        e_rv[i] = 1'b1;
        e_rp[i] = in_entry[i].al_ptr;
      end
    end
    for (int k = 0; k < WR_PORTS; k++) begin
      if (drn && k < occ) begin
        if (mq[k].vld && !m_flushed(mq[k].e.al_ptr, flush_head, flush_tail, flush_en)) begin
          e          = mq[k].e;
          e_alwe[k]  = 1'b1;
          e_rfwe[k]  = e.write_reg;
          e_brv[k]   = e.br_valid;
          e_num[k]   = e.phy_dst;
          e_dat[k]   = e.data;
          e_adr[k]   = e.next_addr;
          e_al[k].ptr = e.al_ptr;
          if (e.br_valid && (e.next_addr % 4) != 0) begin
            e_al[k].state      = EXEC_STATE_FAULT_INSN_MISALIGNED;
            e_al[k].fault_addr = e.next_addr;
          end else begin
            e_al[k].state = e.br_miss ? EXEC_STATE_REFETCH_NEXT : EXEC_STATE_SUCCESS;
          end
        end
      end
    end
    chk("in_ready", in_ready, rdy);
    chk("occupancy", occupancy, occ);
    chk("replay_valid", replay_valid, e_rv);
    chk("replay_al_ptr", replay_al_ptr, e_rp);
    chk("rf_we", rf_we, e_rfwe);
    chk("rf_num", rf_num, e_num);
    chk("rf_data", rf_data, e_dat);
    chk("al_we", al_we, e_alwe);
    chk("al_data", al_data, e_al);
    chk("br_valid", br_valid, e_brv);
    chk("br_next_addr", br_next_addr, e_adr);
  endtask

  // Advance the model across the coming clock edge, then move to the next drive point.
  task automatic step();
    bit rdy;
    int n;
    rdy = (DEPTH - mq.size()) >= LANES;
    if (rst || clear) begin
      mq.delete();
    end else if (!stall) begin
      n = (mq.size() < WR_PORTS) ? mq.size() : WR_PORTS;
      repeat (n) void'(mq.pop_front());
      foreach (mq[j])
        if (m_flushed(mq[j].e.al_ptr, flush_head, flush_tail, flush_en)) mq[j].vld = 1'b0;
      if (rdy) begin
        for (int i = 0; i < LANES; i++) begin
          if (in_valid[i] && in_entry[i].data_valid &&
              !m_flushed(in_entry[i].al_ptr, flush_head, flush_tail, flush_en))
            mq.push_back('{e: in_entry[i], vld: 1'b1});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain_empty();
    idle();
    for (int c = 0; c < 20 && mq.size() != 0; c++) begin
      look();
      step();
    end
  endtask

  task automatic push_group(input int base_ptr, input int base_phy);
    in_valid = '1;
    for (int i = 0; i < LANES; i++)
      in_entry[i] = mk(base_ptr + i, base_phy + i, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'(base_phy * 16 + i));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    look();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_replay", replay_valid, 0);
    step();

    // Four-lane burst drains two per cycle in age order
    push_group(0, 1);
    look();
    step();
    idle();
    look();
    chk("burst_c1_occ", occupancy, 4);
    chk("burst_c1_rf_we", rf_we, 2'b11);
    chk("burst_c1_rf_num", rf_num, {7'd2, 7'd1});
    step();
    look();
    chk("burst_c2_occ", occupancy, 2);
    chk("burst_c2_rf_num", rf_num, {7'd4, 7'd3});
    step();
    look();
    chk("burst_c3_occ", occupancy, 0);
    chk("burst_c3_rf_we", rf_we, 0);
    step();

    // Three back-to-back groups: the third waits for space
    push_group(8, 10);
    look();
    step();
    push_group(12, 20);
    look();
    chk("grp_b_ready", in_ready, 1);
    step();
    push_group(16, 30);
    look();
    chk("grp_c_held", in_ready, 0);
    chk("grp_c_occ", occupancy, 6);
    step();
    look();
    chk("grp_c_ready", in_ready, 1);
    chk("grp_c_order", rf_num, {7'd21, 7'd20});
    step();
    drain_empty();

    // Data-invalid lane goes to replay, not to the buffer
    push_group(20, 40);
    in_entry[1] = mk(9, 41, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look();
    chk("replay_lane1", replay_valid, 4'b0010);
    chk("replay_ptr9", replay_al_ptr[1], 9);
    step();
    idle();
    look();
    chk("replay_skip_num", rf_num, {7'd42, 7'd40});
    step();
    look();
    chk("replay_last_we", al_we, 2'b01);
    step();
    drain_empty();

    // Flush [4,6) over buffered ptrs 3,4,5
    in_valid = 4'b0111;
    for (int i = 0; i < 3; i++) in_entry[i] = mk(3 + i, 50 + i, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    look();
    step();
    idle();
    flush_en = 1'b1; flush_head = 6'd4; flush_tail = 6'd6;
    look();
    chk("flush_rf_we", rf_we, 2'b01);
    chk("flush_al_we", al_we, 2'b01);
    chk("flush_ptr3", al_data[0].ptr, 3);
    step();
    idle();
    look();
    chk("flush_pop_we", al_we, 2'b00);
    chk("flush_pop_occ", occupancy, 1);
    step();
    look();
    chk("flush_empty", occupancy, 0);
    step();

    // Misaligned branch target
    in_valid = 4'b0001;
    in_entry[0] = mk(7, 60, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1002, 32'h5);
    look();
    step();
    idle();
    look();
    chk("mis_state", al_data[0].state, EXEC_STATE_FAULT_INSN_MISALIGNED);
    chk("mis_fault_addr", al_data[0].fault_addr, 32'h1002);
    chk("mis_br_valid", br_valid[0], 1);
    step();
    drain_empty();

    // clear under stall with occupancy 5
    push_group(24, 70);
    look();
    step();
    push_group(28, 80);
    in_valid = 4'b0111;
    look();
    step();
    idle();
    stall = 1'b1; clear = 1'b1; in_valid = '1;
    look();
    chk("clr_occ_before", occupancy, 5);
    chk("clr_no_we", {rf_we, al_we, br_valid, replay_valid}, 0);
    step();
    idle();
    look();
    chk("clr_occ_after", occupancy, 0);
    chk("clr_ready", in_ready, 1);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      idle();
      rst      = (c == 700);
      stall    = ($urandom_range(0, 9) == 0);
      clear    = ($urandom_range(0, 39) == 0);
      flush_en = ($urandom_range(0, 6) == 0);
      flush_head = ALPTR_W'($urandom_range(0, 15));
      flush_tail = ALPTR_W'($urandom_range(0, 15));
      for (int i = 0; i < LANES; i++) begin
        logic [31:0] na;
        na = $urandom;
        if ($urandom_range(0, 1) == 1) na[1:0] = 2'b00;
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_entry[i] = mk($urandom_range(0, 15), $urandom_range(0, 127), $urandom_range(0, 3) != 0,
                         $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1, na, $urandom);
      end
      look();
      step();
    end
    rst = 1'b0;
    drain_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
